change_dispenser: RTL and testbench

//  Pays out vending-machine change through a coin hopper, one coin at a time.

---
 rtl/change_dispenser.sv | 187 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount (0.1-yuan units) greedily with
// 5-yuan, 1-yuan and 5-jiao coins through a single coin hopper. Each coin
// is a fixed-width drive pulse followed by an acknowledge window; a coin
// that never drops marks its denomination as empty.
module change_dispenser #(
  parameter int PULSE_CYCLES = 50,
  parameter int ACK_TIMEOUT  = 1000,
  parameter int INIT_5Y      = 10,
  parameter int INIT_1Y      = 10,
  parameter int INIT_5J      = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       refill,
  input  logic       coin_ack,
  output logic [2:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [6:0] remaining,
  output logic [7:0] inv_5y,
  output logic [7:0] inv_1y,
  output logic [7:0] inv_5j
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    DRIVE    = 3'd2,
    WAIT_ACK = 3'd3,
    FINISH   = 3'd4
  } state_t;

  // Counters only ever hold PARAM-1, so clog2 of the parameter is enough.
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  // Index 0 = 5 jiao, 1 = 1 yuan, 2 = 5 yuan (matches coin_out bit order).
  localparam logic [6:0] COIN_VAL [3] = '{7'd5, 7'd10, 7'd50};
  localparam logic [7:0] INIT_INV [3] = '{8'(INIT_5J), 8'(INIT_1Y), 8'(INIT_5Y)};

  state_t          state_reg, state_next;
  logic [2:0]      coin_reg, coin_next;          // coin currently being paid
  logic [2:0]      coin_out_reg, coin_out_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            short_reg, short_next;
  logic [6:0]      remaining_reg, remaining_next;
  logic [7:0]      inv_reg [3];
  logic [7:0]      inv_next [3];
  logic            ack_seen_reg, ack_seen_next;
  logic [PW-1:0]   pulse_cnt_reg, pulse_cnt_next;
  logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;

  logic [2:0]      fit;
  logic [2:0]      pick;

  // A denomination fits when it is in stock and not worth more than what is owed.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fit
      assign fit[gi] = (inv_reg[gi] != 8'd0) && (COIN_VAL[gi] <= remaining_reg);
    end
  endgenerate

  // Greedy choice: largest fitting coin wins.
  assign pick = fit[2] ? 3'b100 :
                fit[1] ? 3'b010 :
                fit[0] ? 3'b001 : 3'b000;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      coin_reg      <= 3'b000;
      coin_out_reg  <= 3'b000;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      short_reg     <= 1'b0;
      remaining_reg <= 7'd0;
      inv_reg       <= INIT_INV;
      ack_seen_reg  <= 1'b0;
      pulse_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      coin_reg      <= coin_next;
      coin_out_reg  <= coin_out_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      short_reg     <= short_next;
      remaining_reg <= remaining_next;
      inv_reg       <= inv_next;
      ack_seen_reg  <= ack_seen_next;
      pulse_cnt_reg <= pulse_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = SELECT;
      SELECT:   state_next = ((remaining_reg != 7'd0) && (pick != 3'b000)) ? DRIVE : FINISH;
      DRIVE:    if (pulse_cnt_reg == '0) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_seen_reg || coin_ack || (tmo_cnt_reg == TW'(ACK_TIMEOUT - 1)))
                  state_next = SELECT;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output and datapath next values; busy/done follow the next state so they are registered.
  always_comb begin
    coin_next      = coin_reg;
    coin_out_next  = coin_out_reg;
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == FINISH);
    short_next     = short_reg;
    remaining_next = remaining_reg;
    inv_next       = inv_reg;
    ack_seen_next  = ack_seen_reg;
    pulse_cnt_next = pulse_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (refill) inv_next = INIT_INV;
        if (start) begin
          remaining_next = amount;
          short_next     = 1'b0;
        end
      end
      SELECT: begin
        if (remaining_reg == 7'd0) begin
          short_next = 1'b0;
        end else if (pick != 3'b000) begin
          coin_next      = pick;
          coin_out_next  = pick;
          pulse_cnt_next = PW'(PULSE_CYCLES - 1);
          ack_seen_next  = 1'b0;
        end else begin
          short_next = 1'b1;
        end
      end
      DRIVE: begin
        // An early drop is remembered; the pulse still runs its full width.
        if (coin_ack) ack_seen_next = 1'b1;
        if (pulse_cnt_reg == '0) begin
          coin_out_next = 3'b000;
          tmo_cnt_next  = '0;
        end else begin
          pulse_cnt_next = pulse_cnt_reg - 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_seen_reg || coin_ack) begin
          for (int i = 0; i < 3; i++) begin
            if (coin_reg[i]) begin
              remaining_next = remaining_reg - COIN_VAL[i];
              if (inv_reg[i] != 8'd0) inv_next[i] = inv_reg[i] - 8'd1;
            end
          end
        end else if (tmo_cnt_reg == TW'(ACK_TIMEOUT - 1)) begin
          // Jam: treat this denomination as empty so the next pick goes smaller.
          for (int i = 0; i < 3; i++) begin
            if (coin_reg[i]) inv_next[i] = 8'd0;
          end
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign coin_out  = coin_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign short     = short_reg;
  assign remaining = remaining_reg;
  assign inv_5y    = inv_reg[2];
  assign inv_1y    = inv_reg[1];
  assign inv_5j    = inv_reg[0];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random change requests checked against
// a greedy payment model kept in plain integers.
module tb_change_dispenser;

  localparam int PC  = 5;
  localparam int AT  = 30;
  localparam int I5Y = 10;
  localparam int I1Y = 10;
  localparam int I5J = 10;
  localparam int VAL [3] = '{5, 10, 50};

  logic       clk = 1'b0;
  logic       rstn, start, refill, coin_ack;
  logic [6:0] amount;
  logic [2:0] coin_out;
  logic       busy, done, short;
  logic [6:0] remaining;
  logic [7:0] inv_5y, inv_1y, inv_5j;

  int total = 0;
  int bad   = 0;
  int m_inv [3];
  int m_rem;

  change_dispenser #(
    .PULSE_CYCLES(PC), .ACK_TIMEOUT(AT),
    .INIT_5Y(I5Y), .INIT_1Y(I1Y), .INIT_5J(I5J)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .amount(amount), .refill(refill),
    .coin_ack(coin_ack), .coin_out(coin_out), .busy(busy), .done(done),
    .short(short), .remaining(remaining),
    .inv_5y(inv_5y), .inv_1y(inv_1y), .inv_5j(inv_5j)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_refill();
    m_inv[0] = I5J;
    m_inv[1] = I1Y;
    m_inv[2] = I5Y;
  endtask

  // Largest denomination in stock whose value does not exceed what is owed.
  function automatic int model_pick();
    for (int k = 2; k >= 0; k--)
      if (m_inv[k] > 0 && VAL[k] <= m_rem) return k;
    return -1;
  endfunction

  task automatic chk_inv(input string tag);
    chk({tag, "_inv5y"}, inv_5y, m_inv[2]);
    chk({tag, "_inv1y"}, inv_1y, m_inv[1]);
    chk({tag, "_inv5j"}, inv_5j, m_inv[0]);
  endtask

  // ack_d: 0..3 = ack that many cycles after the pulse, 4 = ack during the pulse, -1 = random.
  task automatic do_req(input int amt, input bit use_refill, input logic [2:0] jam_mask,
                        input int ack_d, input bit disturb);
    int k, w, cnt, d, ncoins;
    bit first;
    @(negedge clk);
    amount = 7'(amt);
    start  = 1'b1;
    refill = use_refill;
    if (use_refill) model_refill();
    m_rem = amt;
    @(negedge clk);
    start  = 1'b0;
    refill = 1'b0;
    chk("busy_after_start", busy, 1);
    first  = 1'b1;
    ncoins = 0;
    forever begin
      k = model_pick();
      if (m_rem == 0 || k < 0) break;
      cnt = 0;
      while (coin_out == 3'b000 && cnt < AT + 10) begin
        @(negedge clk);
        cnt++;
      end
      if (first) chk("start_to_coin_latency", cnt, 1);
      first = 1'b0;
      chk("coin_sel", coin_out, 32'(1) << k);
      if (coin_out == 3'b000) break;
      d = (ack_d >= 0) ? ack_d : int'($urandom_range(0, 4));
      w = 0;
      while (coin_out != 3'b000 && w < PC + 5) begin
        coin_ack = !jam_mask[k] && d == 4 && w == 1;
        start    = disturb && w == 2;
        refill   = disturb && w == 2;
        amount   = (disturb && w == 2) ? 7'd3 : 7'(amt);
        @(negedge clk);
        w++;
      end
      coin_ack = 1'b0;
      start    = 1'b0;
      refill   = 1'b0;
      chk("pulse_width", w, PC);
      if (jam_mask[k]) begin
        m_inv[k] = 0;
      end else begin
        if (d < 4) begin
          repeat (d) @(negedge clk);
          coin_ack = 1'b1;
          @(negedge clk);
          coin_ack = 1'b0;
        end
        m_rem    -= VAL[k];
        m_inv[k] -= 1;
      end
      ncoins++;
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < AT + 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_seen", done, 1);
    if (ncoins == 0) chk("done_latency", cnt, 1);
    chk("short", short, (m_rem != 0) ? 1 : 0);
    chk("remaining", remaining, m_rem);
    chk("busy_in_finish", busy, 1);
    chk("coin_out_idle", coin_out, 0);
    chk_inv("end");
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_after_finish", busy, 0);
    $display("req amount=%0d refill=%0d jam=%b coins=%0d short=%0d remaining=%0d inv=%0d/%0d/%0d",
             amt, use_refill, jam_mask, ncoins, short, remaining, inv_5y, inv_1y, inv_5j);
  endtask

  initial begin
    int amt;
    bit rf;
    logic [2:0] jm;

    rstn = 1'b0; start = 1'b0; refill = 1'b0; coin_ack = 1'b0; amount = 7'd0;
    repeat (2) @(negedge clk);
    model_refill();
    chk("rst_coin_out", coin_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_remaining", remaining, 0);
    chk_inv("rst");
    rstn = 1'b1;
    $display("reset released");

    // Basic payment 50+10+5, late acks.
    do_req(65, 1'b0, 3'b000, 3, 1'b0);
    // Start with refill together; max amount leaves 2 unpaid.
    do_req(127, 1'b1, 3'b000, 0, 1'b0);
    // 1-yuan coin jams; paid with two 5-jiao coins.
    do_req(10, 1'b0, 3'b010, 0, 1'b0);
    // Zero amount.
    do_req(0, 1'b0, 3'b000, 0, 1'b0);
    // Jam 5-yuan and 1-yuan, drain 5-jiao.
    do_req(60, 1'b1, 3'b110, -1, 1'b0);
    // Nothing left to pay with.
    do_req(5, 1'b0, 3'b000, 0, 1'b0);
    // start/refill pulsed while busy must be ignored.
    do_req(35, 1'b1, 3'b000, 4, 1'b1);

    // Reset in the middle of a pulse.
    @(negedge clk);
    amount = 7'd65;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    amt = 0;
    while (coin_out == 3'b000 && amt < 10) begin
      @(negedge clk);
      amt++;
    end
    chk("pre_reset_coin", coin_out, 3'b100);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    model_refill();
    chk("midrst_coin_out", coin_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_remaining", remaining, 0);
    chk_inv("midrst");
    rstn = 1'b1;
    $display("reset during drive");
    do_req(65, 1'b0, 3'b000, -1, 1'b0);

    // Random requests.
    for (int i = 0; i < 10; i++) begin
      amt = int'($urandom_range(0, 127));
      rf  = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 3; j++) jm[j] = ($urandom_range(0, 7) == 0);
      do_req(amt, rf, jm, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
